es_ordered_bs_mac: RTL and testbench
====================================

Name: es_ordered_bs_mac

Overview:
Deterministic stochastic-computing multiply-accumulate unit for N unsigned operands. Each operand becomes an ordered unary (thermometer) bitstream of length 2^DATA_WIDTH; streams are clock-divided against each other, so their AND over all 2^(DATA_WIDTH*NUM_INPUTS) cycles counts the exact product.
- Generalises the two-input ordered bitstream multiplier with a start/done handshake and an optional saturating accumulate across operations.
- Used in the dsc arch_sweep as a drop-in compute core.

Parameters:
- DATA_WIDTH, 5, bits per operand; unary stream length is 2^DATA_WIDTH.
- NUM_INPUTS, 2, operand count, >=1.
- ACC_BITS, 4, extra accumulator headroom bits.
- OUT_WIDTH, DATA_WIDTH*NUM_INPUTS+ACC_BITS, result width. Derived; must not be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- en  in  1  global advance enable; when low, all state freezes
- start  in  1  begin an operation (accepted only in IDLE with en=1)
- acc  in  1  sampled with start; 1 = add product to the previous result, 0 = clear first
- bin_data_in  in  [DATA_WIDTH-1:0] x NUM_INPUTS (unpacked)  operands, latched on start
- busy  out  1  high in RUN and DONE
- bin_data_out  out  OUT_WIDTH  last completed result, held until the next completion
- done  out  1  high while in DONE

Behaviour:
Reset:
- rst=0 at posedge → state IDLE; counters, operand regs and accumulator cleared.
- Outputs: busy=0, done=0, bin_data_out=0.
- Reset mid-RUN or mid-DONE aborts the operation; no done pulse.

Enable:
- All transitions, counter advances and accumulation happen only on cycles with en=1.
- done stays high through en=0 cycles in DONE.

IDLE:
- start=1 and en=1 → latch bin_data_in into x[i].
- Internal sum ← acc ? bin_data_out : 0.
- Counters cnt[i] ← 0; go to RUN.
- start while busy is ignored.

RUN, each en cycle:
- bit = AND over i of (cnt[i] < x[i]).
- If bit=1, sum ← sum+1, saturating at 2^OUT_WIDTH-1.
- Counters advance as a mixed-radix odometer: cnt[0] increments every cycle; cnt[i] increments when cnt[0..i-1] are all at max (2^DATA_WIDTH-1); wrap to 0.
- The terminal cycle has all counters at max. It still accumulates its bit, then goes to DONE.
- RUN length = 2^(DATA_WIDTH*NUM_INPUTS) cycles.

DONE:
- bin_data_out ← sum, registered on entry.
- done=1; next en cycle → IDLE.
- done is a pulse of one en-cycle.

Arithmetic and latency:
- Product is exact: prod x[i] ≤ (2^DATA_WIDTH-1)^NUM_INPUTS < 2^(DATA_WIDTH*NUM_INPUTS).
- Overflow is possible only through accumulation and saturates; it never wraps.
- Latency from start accepted to done high = RUN cycles + 1 (en continuously high).
- NUM_INPUTS=1: plain unary count; result = x[0] after 2^DATA_WIDTH cycles.

Optional Feature:
Macro: ES_ORDERED_EARLY_TERM_EN
- Defined: RUN instead ends after the cycle where cnt[NUM_INPUTS-1] = x[NUM_INPUTS-1]-1 and all lower counters are at max. RUN length becomes x[NUM_INPUTS-1]*2^(DATA_WIDTH*(NUM_INPUTS-1)). If any x[i]=0, IDLE goes directly to DONE with sum unchanged. Result is identical to the non-early build.
- Undefined: fixed RUN length 2^(DATA_WIDTH*NUM_INPUTS) regardless of operands.

Test Plan:
- Defaults, x=(3,7), acc=0, en=1 → done high 1025 cycles after start; bin_data_out=21, busy=1 throughout. With ES_ORDERED_EARLY_TERM_EN: done after 225 cycles, still 21.
- Defaults, x=(31,31) then x=(2,5) with acc=1 → 961, then 971. A third op x=(4,4) with acc=0 → 16.
- DATA_WIDTH=3, NUM_INPUTS=2, ACC_BITS=1, x=(7,7) three times with acc=1 → 49, 98, then saturates at 127.
- x=(0,9), defaults → result 0. Without early-term: done at 1025 cycles. With early-term: done 1 cycle after start.
- en toggled 50% random during x=(3,7) → result 21; number of en-high cycles from start to done = 1025; start pulsed in RUN is ignored.
- rst=0 at RUN cycle 100 → next cycle busy=0, done=0, bin_data_out=0. A new start then completes normally with correct product.

Source files
------------

// File: rtl/es_ordered_bs_mac.sv
// es_ordered_bs_mac: deterministic stochastic-computing MAC over N unsigned
// operands using ordered unary bitstreams that are clock-divided against
// each other, so the AND of the streams counts the exact product.
//
// Ports:
//   clk, rst (sync, active-low), en (global advance enable)
//   start, acc, bin_data_in[NUM_INPUTS] : start handshake, accumulate flag,
//                                         operands latched on start
//   busy, done, bin_data_out            : status and last completed result
//
// Build option: define ES_ORDERED_EARLY_TERM_EN to stop RUN as soon as the
// top operand's stream is exhausted (and skip RUN when an operand is zero).

module es_ordered_bs_mac #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int ACC_BITS   = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH*NUM_INPUTS+ACC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
  output logic                  busy,
  output logic [OUT_WIDTH-1:0]  bin_data_out,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);
  localparam logic [OUT_WIDTH-1:0]  SUM_MAX = '1;
  localparam logic [OUT_WIDTH-1:0]  SUM_ONE = OUT_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] x   [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] cnt [NUM_INPUTS];
  logic [OUT_WIDTH-1:0]  sum;

  logic [NUM_INPUTS-1:0] carry;
  logic                  bit_on;
  logic                  last;
  logic [DATA_WIDTH-1:0] cnt_nxt [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] top_end;
  logic [OUT_WIDTH-1:0]  sum_nxt;
  logic [OUT_WIDTH-1:0]  seed;
`ifdef ES_ORDERED_EARLY_TERM_EN
  logic                  any_zero;
`endif

  // carry[i]: all lower digits of the odometer sit at max,
  // so digit i advances this cycle.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      carry[i] = carry[i-1] & (cnt[i-1] == CNT_MAX);
    end
    bit_on = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bit_on     = bit_on & (cnt[i] < x[i]);
      cnt_nxt[i] = carry[i] ? cnt[i] + CNT_ONE : cnt[i];
    end
    sum_nxt = (bit_on && (sum != SUM_MAX)) ? sum + SUM_ONE : sum;
`ifdef ES_ORDERED_EARLY_TERM_EN
    // past this point every stream AND is zero, so stopping is exact
    top_end = x[NUM_INPUTS-1] - CNT_ONE;
`else
    top_end = CNT_MAX;
`endif
    last = carry[NUM_INPUTS-1] & (cnt[NUM_INPUTS-1] == top_end);
    seed = acc ? bin_data_out : '0;
`ifdef ES_ORDERED_EARLY_TERM_EN
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      any_zero = any_zero | (bin_data_in[i] == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bin_data_out <= '0;
      sum          <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        x[i]   <= '0;
        cnt[i] <= '0;
      end
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              x[i]   <= bin_data_in[i];
              cnt[i] <= '0;
            end
            sum  <= seed;
            busy <= 1'b1;
`ifdef ES_ORDERED_EARLY_TERM_EN
            if (any_zero) begin
              state        <= DONE;
              done         <= 1'b1;
              bin_data_out <= seed;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          sum <= sum_nxt;
          for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt[i] <= cnt_nxt[i];
          end
          if (last) begin
            state        <= DONE;
            done         <= 1'b1;
            bin_data_out <= sum_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_es_ordered_bs_mac.sv
// Bench for es_ordered_bs_mac: directed and randomized operations checked
// against an arithmetic product/accumulate model with saturation.

module tb_es_ordered_bs_mac;

`ifdef ES_ORDERED_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, start_a, acc_a;
  logic [4:0]  din_a [2];
  logic        busy_a, done_a;
  logic [13:0] dout_a;
  logic        en_b, start_b, acc_b;
  logic [2:0]  din_b [2];
  logic        busy_b, done_b;
  logic [6:0]  dout_b;

  int tests = 0;
  int fails = 0;
  longint exp_a = 0;
  longint exp_b = 0;

  always #5 clk = ~clk;

  es_ordered_bs_mac dut_a (
    .clk(clk), .rst(rst), .en(en_a), .start(start_a), .acc(acc_a),
    .bin_data_in(din_a), .busy(busy_a), .bin_data_out(dout_a),
    .done(done_a)
  );

  es_ordered_bs_mac #(
    .DATA_WIDTH(3), .NUM_INPUTS(2), .ACC_BITS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .start(start_b), .acc(acc_b),
    .bin_data_in(din_b), .busy(busy_b), .bin_data_out(dout_b),
    .done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint acc_model(longint prev, longint prod,
                                       bit accf, int ow);
    longint s;
    longint m;
    s = (accf ? prev : 0) + prod;
    m = (longint'(1) << ow) - 1;
    return (s > m) ? m : s;
  endfunction

  // cycles from the start cycle to the first cycle with done high
  function automatic int lat_exp(int x0, int x1, int dw);
    if (EARLY) begin
      if (x0 == 0 || x1 == 0) return 1;
      return x1 * (1 << dw) + 1;
    end
    return (1 << (2 * dw)) + 1;
  endfunction

  task automatic op_a(input int x0, input int x1, input bit accf,
                      input bit rnd, input string tag);
    int lat;
    int enc;
    bit busy_ok;
    din_a[0] = 5'(x0);
    din_a[1] = 5'(x1);
    acc_a    = accf;
    start_a  = 1'b1;
    en_a     = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    lat = 1;
    enc = 1;
    busy_ok = 1'b1;
    while (!done_a && lat < 6000) begin
      if (!busy_a) busy_ok = 1'b0;
      if (rnd) begin
        en_a     = 1'($urandom_range(0, 1));
        start_a  = ($urandom_range(0, 15) == 0);
        din_a[0] = 5'($urandom);
        din_a[1] = 5'($urandom);
        acc_a    = 1'($urandom);
      end
      @(posedge clk);
      if (en_a) enc++;
      #1;
      lat++;
    end
    start_a = 1'b0;
    exp_a = acc_model(exp_a, longint'(x0 * x1), accf, 14);
    check({tag, "_result"}, dout_a, exp_a);
    if (rnd) check({tag, "_en_cycles"}, enc, lat_exp(x0, x1, 5));
    else check({tag, "_latency"}, lat, lat_exp(x0, x1, 5));
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_busy_done"}, busy_a, 1);
    if (rnd) begin
      en_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_done_hold"}, done_a, 1);
    end
    en_a = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done_a, 0);
    check({tag, "_idle_busy"}, busy_a, 0);
    check({tag, "_held"}, dout_a, exp_a);
  endtask

  task automatic op_b(input int x0, input int x1, input bit accf,
                      input string tag);
    int lat;
    din_b[0] = 3'(x0);
    din_b[1] = 3'(x1);
    acc_b    = accf;
    start_b  = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_b = acc_model(exp_b, longint'(x0 * x1), accf, 7);
    check({tag, "_result"}, dout_b, exp_b);
    check({tag, "_latency"}, lat, lat_exp(x0, x1, 3));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done_b, 0);
  endtask

  initial begin
    rst = 1'b0;
    en_a = 1'b1; start_a = 1'b0; acc_a = 1'b0;
    din_a[0] = '0; din_a[1] = '0;
    en_b = 1'b1; start_b = 1'b0; acc_b = 1'b0;
    din_b[0] = '0; din_b[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_dout_a", dout_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_dout_b", dout_b, 0);

    op_a(3, 7, 1'b0, 1'b0, "p3x7");
    op_a(31, 31, 1'b0, 1'b0, "p31x31");
    op_a(2, 5, 1'b1, 1'b0, "acc2x5");
    op_a(4, 4, 1'b0, 1'b0, "clr4x4");
    op_a(0, 9, 1'b0, 1'b0, "zero0x9");

    op_b(7, 7, 1'b1, "sat1");
    op_b(7, 7, 1'b1, "sat2");
    op_b(7, 7, 1'b1, "sat3");

    op_a(3, 7, 1'b0, 1'b1, "rnd_en");

    for (int k = 0; k < 3; k++) begin
      op_a($urandom_range(0, 31), $urandom_range(0, 31),
           1'($urandom), 1'b0, "rnd_op");
    end

    din_a[0] = 5'd31;
    din_a[1] = 5'd31;
    acc_a = 1'b0;
    start_a = 1'b1;
    en_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_a = 0;
    exp_b = 0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_dout", dout_a, 0);
    op_a(6, 9, 1'b1, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
